seg7_scan_driver: RTL and testbench

Display back end for the clock top: consumes the muxed seconds/minutes/hours fields and drives a six-digit, time-multiplexed, common-anode seven-segment display. Scans one digit per refresh tick, converts each binary field to two decimal digits, and latches all fields once per frame so a displayed frame never mixes two time values. Blanks selected fields on a slow cadence so the user can see which field is being edited.

---
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed common-anode seven-segment driver for the clock top.
// Inputs are latched once per frame, and selected fields blink on a slow frame-based cadence.
module seg7_scan_driver #(
  parameter int unsigned P_SCAN_DIV     = 50000,
  parameter int unsigned P_BLINK_FRAMES = 50
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hr,
  input  logic [2:0] i_blink_mask,
  output logic [5:0] o_an,
  output logic [6:0] o_seg
);

  localparam int unsigned PRESC_W = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
  localparam int unsigned FRM_W   = (P_BLINK_FRAMES > 2) ? $clog2(P_BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(P_SCAN_DIV - 1);
  localparam logic [FRM_W-1:0]   FRM_LAST   = FRM_W'(P_BLINK_FRAMES - 1);
  localparam logic [6:0]         SEG_BLANK  = 7'b1111111;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic               phase_q, phase_d;
  logic [5:0]         sec_s_q, sec_s_d, min_s_q, min_s_d;
  logic [4:0]         hr_s_q, hr_s_d;
  logic [2:0]         mask_s_q, mask_s_d;
  logic               phase_s_q, phase_s_d;
  logic [5:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic       tick, frame_start;
  logic [2:0] idx_nxt;
  logic [5:0] src_sec, src_min, val;
  logic [4:0] src_hr;
  logic [2:0] src_mask;
  logic       src_phase, field_blink;
  logic [3:0] digit;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    frm_d     = frm_q;
    phase_d   = phase_q;
    sec_s_d   = sec_s_q;
    min_s_d   = min_s_q;
    hr_s_d    = hr_s_q;
    mask_s_d  = mask_s_q;
    phase_s_d = phase_s_q;
    an_d      = an_q;
    seg_d     = seg_q;

    tick        = (presc_q == PRESC_LAST);
    frame_start = tick && (idx_q == 3'd5);
    idx_nxt     = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    // Digit 0 reads the live inputs because the snapshot is being loaded on the same edge
    src_sec   = frame_start ? i_sec        : sec_s_q;
    src_min   = frame_start ? i_min        : min_s_q;
    src_hr    = frame_start ? i_hr         : hr_s_q;
    src_mask  = frame_start ? i_blink_mask : mask_s_q;
    src_phase = frame_start ? phase_q      : phase_s_q;

    case (idx_nxt[2:1])
      2'd0:    begin val = src_sec;         field_blink = src_mask[0]; end
      2'd1:    begin val = src_min;         field_blink = src_mask[1]; end
      default: begin val = {1'b0, src_hr}; field_blink = src_mask[2]; end
    endcase
    digit = idx_nxt[0] ? 4'(val / 6'd10) : 4'(val % 6'd10);

    if (tick) begin
      presc_d = '0;
      idx_d   = idx_nxt;
      an_d    = ~(6'b000001 << idx_nxt);
      seg_d   = (src_phase && field_blink) ? SEG_BLANK : seg_enc(digit);
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    // The frame's blink phase is the value before this frame start's update
    if (frame_start) begin
      sec_s_d   = i_sec;
      min_s_d   = i_min;
      hr_s_d    = i_hr;
      mask_s_d  = i_blink_mask;
      phase_s_d = phase_q;
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      presc_q   <= '0;
      idx_q     <= 3'd5;
      frm_q     <= '0;
      phase_q   <= 1'b0;
      sec_s_q   <= '0;
      min_s_q   <= '0;
      hr_s_q    <= '0;
      mask_s_q  <= '0;
      phase_s_q <= 1'b0;
      an_q      <= 6'b111111;
      seg_q     <= SEG_BLANK;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      frm_q     <= frm_d;
      phase_q   <= phase_d;
      sec_s_q   <= sec_s_d;
      min_s_q   <= min_s_d;
      hr_s_q    <= hr_s_d;
      mask_s_q  <= mask_s_d;
      phase_s_q <= phase_s_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame vectors feed a scoreboard of expected digits,
// which a monitor pops each time the DUT moves to a new digit.
module tb_seg7_scan_driver;

  localparam int unsigned SCAN  = 4;
  localparam int unsigned BLINK = 2;
  localparam int unsigned FRAME = 6 * SCAN;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic [2:0] mask;
  logic [5:0] an;
  logic [6:0] seg;

  seg7_scan_driver #(.P_SCAN_DIV(SCAN), .P_BLINK_FRAMES(BLINK)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_sec(sec), .i_min(min), .i_hr(hr),
    .i_blink_mask(mask), .o_an(an), .o_seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
  } exp_t;

  typedef struct {
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hr;
    logic [2:0]  mask;
    logic [23:0] bcd;   // expected digits {d5,d4,d3,d2,d1,d0}
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame_no = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0: seg_lut = 7'b1000000;
      4'd1: seg_lut = 7'b1111001;
      4'd2: seg_lut = 7'b0100100;
      4'd3: seg_lut = 7'b0110000;
      4'd4: seg_lut = 7'b0011001;
      4'd5: seg_lut = 7'b0010010;
      4'd6: seg_lut = 7'b0000010;
      4'd7: seg_lut = 7'b1111000;
      4'd8: seg_lut = 7'b0000000;
      4'd9: seg_lut = 7'b0010000;
      default: seg_lut = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                       input logic [2:0] k);
    sec = s; min = m; hr = h; mask = k;
  endtask

  // Queue the expected output of the next frame; blink phase follows frame count since reset
  task automatic push_frame(input logic [23:0] bcd, input logic [2:0] k, input int ndig);
    logic       phase;
    logic       blank;
    logic [3:0] dg;
    exp_t       e;
    phase = ((frame_no / BLINK) % 2) == 1;
    for (int d = 0; d < ndig; d++) begin
      dg    = bcd[d*4 +: 4];
      blank = phase && k[d/2];
      e.an  = ~(6'(6'b000001 << d));
      e.seg = blank ? 7'b1111111 : seg_lut(dg);
      sb.push_back(e);
    end
    frame_no++;
  endtask

  task automatic monitor();
    logic [5:0] prev_an;
    int         last_cyc;
    exp_t       e;
    prev_an  = 6'b111111;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_an  = an;
        last_cyc = 0;
      end else if (an !== prev_an) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL digit_unexpected: got an=%b seg=%b, expected no new digit", an, seg);
        end else begin
          e = sb.pop_front();
          if (an !== e.an || seg !== e.seg || (cyc - last_cyc) != SCAN) begin
            n_fail++;
            $display("FAIL digit: got an=%b seg=%b hold=%0d expected an=%b seg=%b hold=%0d",
                     an, seg, cyc - last_cyc, e.an, e.seg, SCAN);
          end
        end
        prev_an  = an;
        last_cyc = cyc;
      end
    end
  endtask

  initial begin
    vecs[0] = '{6'd59, 6'd7,  5'd23, 3'b000, 24'h230759};
    vecs[1] = '{6'd63, 6'd0,  5'd31, 3'b010, 24'h310063};
    vecs[2] = '{6'd5,  6'd7,  5'd0,  3'b010, 24'h000705};
    vecs[3] = '{6'd45, 6'd12, 5'd9,  3'b111, 24'h091245};
    vecs[4] = '{6'd34, 6'd58, 5'd12, 3'b111, 24'h125834};
    vecs[5] = '{6'd0,  6'd0,  5'd0,  3'b000, 24'h000000};
    vecs[6] = '{6'd63, 6'd63, 5'd31, 3'b100, 24'h316363};

    rstn = 1'b0;
    drive(6'd0, 6'd0, 5'd0, 3'b000);
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'h3f);
    check("reset_seg", 32'(seg), 32'h7f);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].sec, vecs[i].min, vecs[i].hr, vecs[i].mask);
      push_frame(vecs[i].bcd, vecs[i].mask, 6);
      if (i == 0) rstn = 1'b1;
      repeat (FRAME) @(negedge clk);
    end

    // Mid-frame input change must wait for the next frame
    drive(6'd12, 6'd0, 5'd0, 3'b000);
    push_frame(24'h000012, 3'b000, 6);
    repeat (5) @(negedge clk);
    sec = 6'd34;
    repeat (FRAME - 5) @(negedge clk);
    push_frame(24'h000034, 3'b000, 6);
    repeat (FRAME) @(negedge clk);

    drive(6'd1, 6'd2, 5'd3, 3'b000);
    push_frame(24'h030201, 3'b000, 6);
    repeat (FRAME) @(negedge clk);

    // Reset while digit 3 is shown, in a blanking frame
    drive(6'd45, 6'd45, 5'd19, 3'b111);
    push_frame(24'h194545, 3'b111, 4);
    repeat (3 * SCAN + SCAN / 2 + 2) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midreset_an", 32'(an), 32'h3f);
    check("midreset_seg", 32'(seg), 32'h7f);
    check("midreset_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    frame_no = 0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      drive(6'd8, 6'd30, 5'd12, 3'b111);
      push_frame(24'h123008, 3'b111, 6);
      if (i == 0) rstn = 1'b1;
      repeat (FRAME) @(negedge clk);
    end

    for (int t = 0; t < 100 && sb.size() > 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
